decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage for the pP core. It cracks one instruction per cycle into kind, function and register fields. It holds the result in an output register with valid/ready handshakes on both sides and tracks outstanding register writes in a scoreboard, so read-after-write and write-after-write hazards stall issue. It sits between fetch and execute/register-read and replaces the purely combinational decoder.

---
 rtl/decode_stage.sv | 167 ++++++++++++++++
 tb/tb_decode_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with valid/ready on both sides.
// A write scoreboard plus a held-result compare stalls RAW/WAW hazards.
module decode_stage #(
  parameter  int REG_AW = 3,
  parameter  int DATA_W = 8,
  localparam int INST_W = DATA_W + 2*REG_AW + 5,
  localparam int ADDR_W = DATA_W + REG_AW + 1,
  localparam int SC_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic              inst_ready,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [3:0]        kind,
  output logic [2:0]        fn3,
  output logic [1:0]        fn2,
  output logic [REG_AW-1:0] waddr,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] imm,
  output logic [SC_W-1:0]   sc,
  output logic [ADDR_W-1:0] jaddr,
  output logic              illegal,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  output logic [15:0]       hz_cnt
);

  localparam int T  = INST_W;
  localparam int D  = DATA_W;
  localparam int A  = REG_AW;
  localparam int NR = 1 << A;
  localparam logic [NR-1:0] ONE = 1;

  typedef struct packed {
    logic [3:0]        kind;
    logic [2:0]        fn3;
    logic [1:0]        fn2;
    logic [A-1:0]      waddr;
    logic [A-1:0]      raddr1;
    logic [A-1:0]      raddr2;
    logic [D-1:0]      imm;
    logic [SC_W-1:0]   sc;
    logic [ADDR_W-1:0] jaddr;
    logic              illegal;
  } dec_t;

  dec_t          dec_d, dec_q;
  logic          dv_d, dv_q;
  logic [NR-1:0] pend_d, pend_q;
  logic [15:0]   hz_d, hz_q;

  logic [1:0] op2;
  logic [2:0] op3;
  logic [4:0] op5;
  logic [5:0] op6;
  logic [3:0] k;
  logic k_fn3, k_fn2, k_wr, k_r2;
  logic k_sc, k_imm, k_j;

  assign op2 = inst[T-1 -: 2];
  assign op3 = inst[T-1 -: 3];
  assign op5 = inst[T-1 -: 5];
  assign op6 = inst[T-1 -: 6];

  // Opcode prefixes are disjoint, so match order is irrelevant.
  always_comb begin
    k = 4'd15;
    unique case (1'b1)
      op2 == 2'b00:     k = 4'd0;
      op2 == 2'b01:     k = 4'd1;
      op3 == 3'b110:    k = 4'd2;
      op3 == 3'b100:    k = 4'd3;
      op3 == 3'b101:    k = 4'd4;
      op5 == 5'b11100:  k = 4'd5;
      op5 == 5'b11101:  k = 4'd6;
      op6 == 6'b111100: k = 4'd7;
      op6 == 6'b111101: k = 4'd8;
      op6 == 6'b111110: k = 4'd9;
      op6 == 6'b111111: k = 4'd10;
      default:          k = 4'd15;
    endcase
  end

  assign k_fn3 = k <= 4'd1;
  assign k_fn2 = (k >= 4'd2) && (k <= 4'd4);
  assign k_wr  = k <= 4'd3;
  assign k_r2  = k == 4'd0;
  assign k_sc  = k == 4'd2;
  assign k_imm = (k == 4'd1) || (k == 4'd3) || (k == 4'd4);
  assign k_j   = (k == 4'd5) || (k == 4'd6);

  always_comb begin
    dec_d         = '0;
    dec_d.kind    = k;
    dec_d.illegal = k == 4'd15;
    if (k_fn3) dec_d.fn3    = inst[T-3 -: 3];
    if (k_fn2) dec_d.fn2    = inst[T-4 -: 2];
    if (k_wr)  dec_d.waddr  = inst[D+2*A-1 -: A];
    if (k_wr)  dec_d.raddr1 = inst[D+A-1 -: A];
    if (k_r2)  dec_d.raddr2 = inst[D-1 -: A];
    if (k_sc)  dec_d.sc     = inst[D-1 -: SC_W];
    if (k_imm) dec_d.imm    = inst[D-1:0];
    if (k_j)   dec_d.jaddr  = inst[ADDR_W-1:0];
  end

  logic          held_wr, leave, hazard, accept;
  logic [NR-1:0] wb_oh, set_oh, busy;

  assign held_wr = dv_q && (dec_q.kind <= 4'd3);
  assign leave   = dv_q & dec_ready & ~flush;
  assign wb_oh   = wb_valid ? (ONE << wb_addr) : '0;
  assign set_oh  = (leave & held_wr) ? (ONE << dec_q.waddr) : '0;

  // The held write is checked even while it leaves: its pend bit
  // only becomes visible the cycle after.
  assign busy = (pend_q & ~wb_oh)
              | (held_wr ? (ONE << dec_q.waddr) : '0);

  assign hazard = (k_wr & (busy[dec_d.waddr] | busy[dec_d.raddr1]))
                | (k_r2 & busy[dec_d.raddr2]);

  assign inst_ready = ~flush & ~hazard & (~dv_q | dec_ready);
  assign accept     = inst_valid & inst_ready;

  assign dv_d   = ~flush & (accept | (dv_q & ~dec_ready));
  assign pend_d = (pend_q & ~wb_oh) | set_oh;

  always_comb begin
    hz_d = hz_q;
    if (inst_valid & ~flush & hazard & (~dv_q | dec_ready)
        & (hz_q != 16'hFFFF))
      hz_d = hz_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q   <= 1'b0;
      dec_q  <= '0;
      pend_q <= '0;
      hz_q   <= '0;
    end else begin
      dv_q   <= dv_d;
      pend_q <= pend_d;
      hz_q   <= hz_d;
      if (accept) dec_q <= dec_d;
    end
  end

  assign dec_valid = dv_q;
  assign kind      = dec_q.kind;
  assign fn3       = dec_q.fn3;
  assign fn2       = dec_q.fn2;
  assign waddr     = dec_q.waddr;
  assign raddr1    = dec_q.raddr1;
  assign raddr2    = dec_q.raddr2;
  assign imm       = dec_q.imm;
  assign sc        = dec_q.sc;
  assign jaddr     = dec_q.jaddr;
  assign illegal   = dec_q.illegal;
  assign hz_cnt    = hz_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage.
// Expected decodes are queued on acceptance and checked on output.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, inst_valid, dec_ready;
  logic [18:0] inst;
  logic        inst_ready, dec_valid, illegal;
  logic [3:0]  kind;
  logic [2:0]  fn3, waddr, raddr1, raddr2, sc;
  logic [1:0]  fn2;
  logic [7:0]  imm;
  logic [11:0] jaddr;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] hz_cnt;

  int n_vec = 0;
  int n_bad = 0;
  logic [41:0] sbq[$];
  logic [41:0] got_pk;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .kind(kind), .fn3(fn3),
    .fn2(fn2), .waddr(waddr), .raddr1(raddr1),
    .raddr2(raddr2), .imm(imm), .sc(sc),
    .jaddr(jaddr), .illegal(illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .hz_cnt(hz_cnt)
  );

  assign got_pk = {kind, fn3, fn2, waddr, raddr1, raddr2,
                   imm, sc, jaddr, illegal};

  localparam logic [18:0] W0   = 19'b00_101_010_011_100_00000;
  localparam logic [18:0] RD2  = {2'b01, 3'd1, 3'd1, 3'd2, 8'h33};
  localparam logic [18:0] CJSB = {5'b11101, 2'b00, 12'h557};
  localparam logic [18:0] BR   = {3'b101, 2'b10, 3'd0, 3'd0, 8'hA5};
  localparam logic [18:0] MEM  = {3'b100, 2'b01, 3'd6, 3'd7, 8'h80};
  localparam logic [18:0] RET  = {6'b111100, 13'h1abc};
  localparam logic [18:0] JMP  = {5'b11100, 2'b11, 12'hFFF};
  localparam logic [18:0] SHF  = {3'b110, 2'b11, 3'd0, 3'd4, 3'd5, 5'b10101};
  localparam logic [18:0] RETI = {6'b111101, 13'h0000};
  localparam logic [18:0] ENAI = {6'b111110, 13'h0123};
  localparam logic [18:0] DISI = {6'b111111, 13'h1fff};
  localparam logic [18:0] W5   = {2'b00, 3'd2, 3'd5, 3'd0, 3'd1, 5'd0};
  localparam logic [18:0] RD5  = {2'b01, 3'd7, 3'd4, 3'd5, 8'h5A};
  localparam logic [18:0] BA   = {3'b101, 2'b01, 3'd0, 3'd0, 8'h3C};
  localparam logic [18:0] BB   = {5'b11100, 2'b01, 12'h0F0};
  localparam logic [18:0] BD   = {3'b100, 2'b00, 3'd2, 3'd3, 8'h7F};
  localparam logic [18:0] FW   = {2'b00, 3'd1, 3'd7, 3'd0, 3'd1, 5'd0};
  localparam logic [18:0] RD2X = {2'b01, 3'd0, 3'd6, 3'd2, 8'h11};
  localparam logic [18:0] RD7  = {2'b01, 3'd4, 3'd3, 3'd7, 8'h77};

  function automatic logic [41:0] model(input logic [18:0] w);
    logic [3:0]  k;
    logic [2:0]  f3, wa, r1, r2, s;
    logic [1:0]  f2;
    logic [7:0]  im;
    logic [11:0] ja;
    logic        il;
    f3 = '0; f2 = '0; wa = '0; r1 = '0; r2 = '0;
    s = '0; im = '0; ja = '0; il = 1'b0;
    casez (w[18:13])
      6'b00????: k = 4'd0;
      6'b01????: k = 4'd1;
      6'b110???: k = 4'd2;
      6'b100???: k = 4'd3;
      6'b101???: k = 4'd4;
      6'b11100?: k = 4'd5;
      6'b11101?: k = 4'd6;
      6'b111100: k = 4'd7;
      6'b111101: k = 4'd8;
      6'b111110: k = 4'd9;
      6'b111111: k = 4'd10;
      default: begin k = 4'd15; il = 1'b1; end
    endcase
    case (k)
      4'd0: begin f3 = w[16:14]; wa = w[13:11];
                  r1 = w[10:8]; r2 = w[7:5]; end
      4'd1: begin f3 = w[16:14]; wa = w[13:11];
                  r1 = w[10:8]; im = w[7:0]; end
      4'd2: begin f2 = w[15:14]; wa = w[13:11];
                  r1 = w[10:8]; s = w[7:5]; end
      4'd3: begin f2 = w[15:14]; wa = w[13:11];
                  r1 = w[10:8]; im = w[7:0]; end
      4'd4: begin f2 = w[15:14]; im = w[7:0]; end
      4'd5, 4'd6: ja = w[11:0];
      default: ;
    endcase
    return {k, f3, f2, wa, r1, r2, im, s, ja, il};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [18:0] w,
                     input logic rdy, input logic fl,
                     input logic wbv, input logic [2:0] wba);
    @(posedge clk);
    #1;
    inst_valid = v;
    inst       = w;
    dec_ready  = rdy;
    flush      = fl;
    wb_valid   = wbv;
    wb_addr    = wba;
    @(negedge clk);
  endtask

  // Output side of the scoreboard: retire or drop the held entry,
  // then queue whatever is accepted this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dec_valid && (flush || dec_ready)) begin
        chk("sb_depth", 64'(sbq.size()), 64'd1);
        if (sbq.size() > 0) begin
          if (flush) void'(sbq.pop_front());
          else chk("dec", 64'(got_pk), 64'(sbq.pop_front()));
        end
      end else if (dec_valid && sbq.size() > 0) begin
        chk("hold", 64'(got_pk), 64'(sbq[0]));
      end
      if (inst_valid && inst_ready) sbq.push_back(model(inst));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [18:0] tp[4];
    tp = '{SHF, RETI, ENAI, DISI};
    rst_n = 1'b0; flush = 1'b0; inst_valid = 1'b0; inst = '0;
    dec_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_dv", 64'(dec_valid), 64'd0);
    chk("rst_fields", 64'(got_pk), 64'd0);
    chk("rst_hz", 64'(hz_cnt), 64'd0);
    chk("rst_rdy", 64'(inst_ready), 64'd1);
    @(posedge clk); #1; rst_n = 1'b1;

    cyc(1, W0, 1, 0, 0, 0);
    chk("w0_rdy", 64'(inst_ready), 64'd1);
    cyc(0, '0, 1, 0, 0, 0);
    chk("w0_dv", 64'(dec_valid), 64'd1);
    chk("w0_fields",
        64'({kind, fn3, waddr, raddr1, raddr2, imm, jaddr}),
        64'({4'd0, 3'd5, 3'd2, 3'd3, 3'd4, 8'd0, 12'd0}));

    for (int i = 0; i < 3; i++) begin
      cyc(1, RD2, 1, 0, 0, 0);
      chk("raw_stall", 64'(inst_ready), 64'd0);
    end
    cyc(1, RD2, 1, 0, 1, 3'd2);
    chk("raw_wb_rdy", 64'(inst_ready), 64'd1);
    chk("hz_raw", 64'(hz_cnt), 64'd3);
    cyc(0, '0, 1, 0, 0, 0);

    cyc(1, BR, 1, 0, 0, 0);
    chk("tp_rdy", 64'(inst_ready), 64'd1);
    cyc(1, CJSB, 1, 0, 0, 0);
    chk("tp_rdy", 64'(inst_ready), 64'd1);
    cyc(1, MEM, 1, 0, 0, 0);
    chk("tp_rdy", 64'(inst_ready), 64'd1);
    chk("jsb", 64'({kind, jaddr, waddr, illegal}),
        64'({4'd6, 12'h557, 3'd0, 1'b0}));
    cyc(1, RET, 1, 0, 0, 0);
    chk("tp_rdy", 64'(inst_ready), 64'd1);
    cyc(1, JMP, 1, 0, 0, 0);
    chk("tp_rdy", 64'(inst_ready), 64'd1);
    chk("ret_kind", 64'(kind), 64'd7);
    for (int i = 0; i < 4; i++) begin
      cyc(1, tp[i], 1, 0, 0, 0);
      chk("tp_rdy", 64'(inst_ready), 64'd1);
    end
    cyc(0, '0, 1, 0, 0, 0);
    chk("tp_last_dv", 64'(dec_valid), 64'd1);
    cyc(0, '0, 1, 0, 0, 0);
    chk("tp_idle_dv", 64'(dec_valid), 64'd0);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0, 1, 3'(i));

    cyc(1, W5, 1, 0, 0, 0);
    chk("b2b_rdy", 64'(inst_ready), 64'd1);
    cyc(1, RD5, 1, 0, 0, 0);
    chk("b2b_stall0", 64'(inst_ready), 64'd0);
    cyc(1, RD5, 1, 0, 0, 0);
    chk("b2b_stall1", 64'(inst_ready), 64'd0);
    cyc(1, RD5, 1, 0, 1, 3'd5);
    chk("b2b_wb", 64'(inst_ready), 64'd1);
    chk("hz_b2b", 64'(hz_cnt), 64'd5);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 1, 0, 1, 3'd4);

    cyc(1, BA, 0, 0, 0, 0);
    chk("bp_rdy0", 64'(inst_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, BB, 0, 0, 0, 0);
      chk("bp_rdy", 64'(inst_ready), 64'd0);
      chk("bp_hold", 64'(got_pk), 64'(model(BA)));
    end
    cyc(1, BB, 1, 0, 0, 0);
    chk("bp_rel", 64'(inst_ready), 64'd1);
    cyc(1, ENAI, 1, 0, 0, 0);
    chk("bp_rel", 64'(inst_ready), 64'd1);
    cyc(1, BD, 1, 0, 0, 0);
    chk("bp_rel", 64'(inst_ready), 64'd1);
    // BD (writes r2) leaves while r2 is written back: set wins.
    cyc(0, '0, 1, 0, 1, 3'd2);

    cyc(1, FW, 0, 0, 0, 0);
    chk("fl_acc", 64'(inst_ready), 64'd1);
    cyc(0, '0, 1, 1, 0, 0);
    chk("fl_rdy", 64'(inst_ready), 64'd0);
    cyc(1, RD2X, 1, 0, 0, 0);
    chk("fl_dv", 64'(dec_valid), 64'd0);
    chk("fl_pend_kept", 64'(inst_ready), 64'd0);
    cyc(1, RD7, 0, 0, 0, 0);
    chk("fl_no_set", 64'(inst_ready), 64'd1);
    chk("hz_fl", 64'(hz_cnt), 64'd6);

    cyc(1, RD2X, 0, 0, 0, 0);
    chk("stall_pre", 64'(inst_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("mrst_dv", 64'(dec_valid), 64'd0);
    chk("mrst_fields", 64'(got_pk), 64'd0);
    chk("mrst_hz", 64'(hz_cnt), 64'd0);
    chk("mrst_pend", 64'(inst_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dec_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 64'(inst_ready), 64'd1);
    cyc(0, '0, 1, 0, 0, 0);
    chk("post_rst_dv", 64'(dec_valid), 64'd1);
    cyc(0, '0, 1, 0, 0, 0);
    chk("post_rst_idle", 64'(dec_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
